// File: rtl/operand_sequencer.sv
// Operand sequencer: packs six streamed words into registered operands, launches the
// datapath with a one-cycle start, and returns its result on a valid/ready stream.
module operand_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] i4,
    output logic [WIDTH-1:0] i5,
    output logic [WIDTH-1:0] i6,
    output logic             start,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [2:0] LAST_SLOT = 3'd5;

    state_t           state;
    logic [2:0]       count;
    logic [WIDTH-1:0] ops [6];

    assign i1 = ops[0];
    assign i2 = ops[1];
    assign i3 = ops[2];
    assign i4 = ops[3];
    assign i5 = ops[4];
    assign i6 = ops[5];

    // The handshake flags are registered alongside the state, so every output comes
    // straight from a flop and nothing combinational reaches in_ready/start/out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            count     <= 3'd0;
            // NOTE: the operand registers drive the datapath directly, so they are
            // reset like control state rather than left as uninitialised storage.
            for (int k = 0; k < 6; k++) begin
                ops[k] <= '0;
            end
            out_data  <= '0;
            in_ready  <= 1'b1;
            start     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register
            // samples the pre-edge values, regardless of statement order.
            start <= 1'b0;
            unique case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < 6; k++) begin
                            if (count == 3'(k)) begin
                                ops[k] <= in_data;
                            end
                        end
                        busy <= 1'b1;
                        if (count == LAST_SLOT) begin
                            count    <= 3'd0;
                            state    <= ST_FIRE;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end
                end
                ST_FIRE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Count is already zero here, so LOAD is re-entered idle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: table-driven transactions, hand-written
// reset and idle corner cases, and randomized transactions against a transaction model.
module tb_operand_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] i1, i2, i3, i4, i5, i6;
    logic         start;
    logic         done;
    logic [W-1:0] result;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         busy;

    operand_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .i5       (i5),
        .i6       (i6),
        .start    (start),
        .done     (done),
        .result   (result),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: six words, how gaps are inserted (0 none, 1 alternate, 2 random),
    // WAIT cycles before done, HOLD stall cycles, result, expected start cycle (-1: derive).
    typedef struct {
        logic [5:0][W-1:0] w;
        int                gap_mode;
        int                done_lat;
        int                stall;
        logic [W-1:0]      res;
        int                exp_start;
        logic [W-1:0]      exp_out;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           start_pulses = 0;
    int           exp_pulses = 0;
    logic [W-1:0] prev_res = '0;
    vec_t         tbl [4];

    always @(negedge clk) begin
        if (start === 1'b1) start_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, b, c, d, e, f,
                                input int gm, lat, stall,
                                input logic [W-1:0] res, input int es);
        vec_t v;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
        v.gap_mode  = gm;
        v.done_lat  = lat;
        v.stall     = stall;
        v.res       = res;
        v.exp_start = es;
        v.exp_out   = res;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_i1"}, i1, 0);
        check({tag, "_i2"}, i2, 0);
        check({tag, "_i3"}, i3, 0);
        check({tag, "_i4"}, i4, 0);
        check({tag, "_i5"}, i5, 0);
        check({tag, "_i6"}, i6, 0);
    endtask

    task automatic check_ops(input string tag, input vec_t v);
        check({tag, "_i1"}, i1, v.w[0]);
        check({tag, "_i2"}, i2, v.w[1]);
        check({tag, "_i3"}, i3, v.w[2]);
        check({tag, "_i4"}, i4, v.w[3]);
        check({tag, "_i5"}, i5, v.w[4]);
        check({tag, "_i6"}, i6, v.w[5]);
    endtask

    // Drives one full transaction from an idle LOAD and checks it cycle by cycle.
    // Cycle 0 is the cycle the first word is offered.
    task automatic run_txn(input vec_t v);
        int cyc;
        int sc;
        int exp_sc;
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            int ngap;
            ngap = 0;
            if (k != 0 && v.gap_mode == 1) ngap = 1;
            if (k != 0 && v.gap_mode == 2) ngap = int'($urandom_range(0, 3));
            for (int g = 0; g < ngap; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                done     = 1'($urandom_range(0, 1));
                result   = $urandom;
                check("gap_busy", busy, 1);
                check("gap_out_valid", out_valid, 0);
                tick();
                cyc++;
            end
            in_valid = 1'b1;
            in_data  = v.w[k];
            done     = 1'($urandom_range(0, 1));
            result   = $urandom;
            check("load_in_ready", in_ready, 1);
            check("load_busy", busy, (k != 0));
            check("load_start", start, 0);
            check("load_out_data_kept", out_data, prev_res);
            tick();
            cyc++;
        end
        exp_sc = (v.exp_start < 0) ? cyc : v.exp_start;

        // Upstream keeps offering junk and a bogus done while the launch happens.
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        done     = 1'b1;
        result   = 32'hBAD0_BAD0;
        sc = -1;
        for (int j = 0; j < 4 && sc < 0; j++) begin
            if (start === 1'b1) sc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        check("start_cycle", sc, exp_sc);
        check("fire_in_ready", in_ready, 0);
        check("fire_out_valid", out_valid, 0);
        check_ops("fire", v);
        tick();

        check("wait_start", start, 0);
        check("wait_in_ready", in_ready, 0);
        check("wait_busy", busy, 1);
        for (int j = 0; j < v.done_lat; j++) begin
            done = 1'b0;
            check("wait_out_valid", out_valid, 0);
            tick();
        end
        done   = 1'b1;
        result = v.res;
        tick();
        done   = 1'b0;
        result = $urandom;

        check("hold_out_valid", out_valid, 1);
        check("hold_out_data", out_data, v.exp_out);
        check("hold_in_ready", in_ready, 0);
        check("hold_start", start, 0);
        for (int j = 0; j < v.stall; j++) begin
            out_ready = 1'b0;
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, v.exp_out);
            check("stall_in_ready", in_ready, 0);
        end

        // Release with a word offered in the same cycle: it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("exit_in_ready", in_ready, 1);
        check("exit_out_valid", out_valid, 0);
        check("exit_busy", busy, 0);
        check("exit_out_data", out_data, v.exp_out);
        check_ops("exit", v);
        prev_res = v.exp_out;
        exp_pulses++;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        done      = 1'b0;
        result    = '0;
        out_ready = 1'b0;
        #12;
        check_reset_vals("in_reset");
        #10 rst = 1'b1;
        tick();
        check_reset_vals("released");

        // Basic load (start at cycle 6, done three cycles after start), gapped input
        // with backpressure, then wide and all-zero words.
        tbl[0] = mk(2, 3, 4, 2, 3, 1, 0, 2, 0, 42, 6);
        tbl[1] = mk(2, 3, 4, 2, 3, 1, 1, 0, 5, 7, 11);
        tbl[2] = mk(32'hFFFF_FFFF, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 32'hA5A5_A5A5,
                    0, 5, 2, 32'hFFFF_FFFF, 6);
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 11);
        for (int t = 0; t < 4; t++) begin
            run_txn(tbl[t]);
        end

        // Spurious done while idle in LOAD must not capture anything.
        for (int j = 0; j < 3; j++) begin
            done   = 1'b1;
            result = 32'h5555_0000 + 32'(j);
            tick();
            check("idle_done_out_valid", out_valid, 0);
            check("idle_done_out_data", out_data, prev_res);
            check("idle_done_busy", busy, 0);
        end
        done = 1'b0;

        // Reset in the middle of WAIT abandons the computation.
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        exp_pulses++;
        tick();
        tick();
        check("mid_wait_busy", busy, 1);
        check("mid_wait_in_ready", in_ready, 0);
        check("mid_wait_i1", i1, 32'h100);
        #3 rst = 1'b0;
        #1 check_reset_vals("mid_wait_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        check_reset_vals("after_mid_wait");
        check("no_start_after_reset", start_pulses, exp_pulses);
        prev_res = '0;
        run_txn(mk(32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 0, 1, 1, 32'h77, 6));

        // Randomized transactions: the model expects each operand to be the word sent
        // in that slot and the output to be the result presented with done.
        for (int r = 0; r < 20; r++) begin
            vec_t v;
            v = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   2, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom, -1);
            run_txn(v);
        end

        check("start_pulse_count", start_pulses, exp_pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
